// File: rtl/complex_mul_pkg.sv
// Shared types and constants for the sequential complex multiplier.
package complex_mul_pkg;

    localparam int OP_W    = 8;
    localparam int PROD_W  = 16;
    localparam int RES_W   = 18;
    localparam int N_STEPS = 4;
    localparam int STEP_W  = $clog2(N_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] ar;
        logic [OP_W-1:0] ai;
        logic [OP_W-1:0] br;
        logic [OP_W-1:0] bi;
    } operands_t;

    // Products are unsigned, so widening to the accumulator width is a zero-extend.
    function automatic logic [RES_W-1:0] zext_prod(input logic [PROD_W-1:0] p);
        return {{(RES_W-PROD_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/vedic8.sv
// 8x8 unsigned multiplier built from four 4x4 partial products (Vedic
// vertical-and-crosswise arrangement). Purely combinational.
module vedic8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [7:0] ll;
    logic [7:0] lh;
    logic [7:0] hl;
    logic [7:0] hh;

    assign ll = {4'b0, a[3:0]} * {4'b0, b[3:0]};
    assign lh = {4'b0, a[3:0]} * {4'b0, b[7:4]};
    assign hl = {4'b0, a[7:4]} * {4'b0, b[3:0]};
    assign hh = {4'b0, a[7:4]} * {4'b0, b[7:4]};

    // Vertical terms sit side by side; the two crosswise terms land at bit 4.
    // The true product fits in 16 bits, so the sum cannot carry out.
    assign p = {hh, ll} + {4'b0, lh, 4'b0} + {4'b0, hl, 4'b0};

endmodule

// File: rtl/complex_mul_seq.sv
// Sequential complex multiplier: one shared 8x8 multiplier is stepped through
// the four partial products, accumulating into signed 18-bit re/im registers.
// CONJ_B=1 computes a*conj(b) instead of a*b.
module complex_mul_seq
    import complex_mul_pkg::*;
#(
    parameter bit CONJ_B = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  ar,
    input  logic [OP_W-1:0]  ai,
    input  logic [OP_W-1:0]  br,
    input  logic [OP_W-1:0]  bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] re,
    output logic [RES_W-1:0] im
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    operands_t         ops_q, ops_d;
    logic [RES_W-1:0]  re_q, re_d;
    logic [RES_W-1:0]  im_q, im_d;

    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [PROD_W-1:0] prod;
    logic [RES_W-1:0]  prod_x;

    // Select the multiplier operands for the current step.
    always_comb begin
        mul_a = ops_q.ar;
        mul_b = ops_q.br;
        unique case (step_q)
            2'd0: begin mul_a = ops_q.ar; mul_b = ops_q.br; end
            2'd1: begin mul_a = ops_q.ai; mul_b = ops_q.bi; end
            2'd2: begin
                mul_a = CONJ_B ? ops_q.ai : ops_q.ar;
                mul_b = CONJ_B ? ops_q.br : ops_q.bi;
            end
            2'd3: begin
                mul_a = CONJ_B ? ops_q.ar : ops_q.ai;
                mul_b = CONJ_B ? ops_q.bi : ops_q.br;
            end
            default: ;
        endcase
    end

    vedic8 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    assign prod_x = zext_prod(prod);

    // Next-state, handshake outputs and the single accumulate stage.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ops_d     = ops_q;
        re_d      = re_q;
        im_d      = im_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = MUL;
                    step_d  = '0;
                    ops_d   = '{ar: ar, ai: ai, br: br, bi: bi};
                end
            end

            MUL: begin
                step_d = step_q + 1'b1;
                unique case (step_q)
                    2'd0: re_d = prod_x;
                    2'd1: re_d = CONJ_B ? re_q + prod_x : re_q - prod_x;
                    2'd2: im_d = prod_x;
                    2'd3: im_d = CONJ_B ? im_q - prod_x : im_q + prod_x;
                    default: ;
                endcase
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        // Back-to-back: hand off the result and start the next one.
                        state_d = MUL;
                        step_d  = '0;
                        ops_d   = '{ar: ar, ai: ai, br: br, bi: bi};
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, step counter, operand latch and result registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the result and operand registers are reset too, so re/im read 0
    // after reset rather than an unknown value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            ops_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ops_q   <= ops_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign re = re_q;
    assign im = im_q;

endmodule

// File: tb/tb_complex_mul_seq.sv
// Bench for complex_mul_seq: one instance per CONJ_B value sharing the same
// stimulus, checked against plain-arithmetic complex products.
module tb_complex_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  ar = '0, ai = '0, br = '0, bi = '0;
    logic        ir0, ov0, ir1, ov1;
    logic [17:0] re0, im0, re1, im1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    complex_mul_seq #(.CONJ_B(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(ov0), .out_ready(out_ready), .re(re0), .im(im0)
    );

    complex_mul_seq #(.CONJ_B(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(ov1), .out_ready(out_ready), .re(re1), .im(im1)
    );

    typedef struct {
        logic [7:0] ar, ai, br, bi;
        int         re0, im0, re1, im1;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sres(input logic [17:0] v);
        return int'($signed(v));
    endfunction

    // Reference: (ar + j ai)(br +/- j bi) with ordinary integer arithmetic.
    function automatic void ref_mul(input int a_r, a_i, b_r, b_i, input bit conj,
                                    output int e_re, output int e_im);
        if (!conj) begin
            e_re = a_r * b_r - a_i * b_i;
            e_im = a_r * b_i + a_i * b_r;
        end else begin
            e_re = a_r * b_r + a_i * b_i;
            e_im = a_i * b_r - a_r * b_i;
        end
    endfunction

    // Count edges until out_valid rises, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ov0) break;
        end
    endtask

    task automatic check_results(input string tag, input int e0r, e0i, e1r, e1i);
        check({tag, "_re0"}, sres(re0), e0r);
        check({tag, "_im0"}, sres(im0), e0i);
        check({tag, "_re1"}, sres(re1), e1r);
        check({tag, "_im1"}, sres(im1), e1i);
    endtask

    // One full transaction from IDLE back to IDLE.
    task automatic run_op(input logic [7:0] a_r, a_i, b_r, b_i,
                          input int e0r, e0i, e1r, e1i, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_ready_idle"}, int'(ir0), 1);
        ar = a_r; ai = a_i; br = b_r; bi = b_i;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ar = 8'($urandom); ai = 8'($urandom); br = 8'($urandom); bi = 8'($urandom);
        check({tag, "_ready_mul"}, int'(ir0), 0);
        wait_result(lat);
        check({tag, "_latency"}, lat, 4);
        check({tag, "_valid1"}, int'(ov1), 1);
        check_results(tag, e0r, e0i, e1r, e1i);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, int'(ov0), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, busy;
        int e0r, e0i, e1r, e1i;
        logic [17:0] hold_re, hold_im;
        logic [7:0] r_ar, r_ai, r_br, r_bi;

        vecs[0] = '{8'd3,   8'd4,   8'd5,   8'd6,   -9,     38,     39,     2};
        vecs[1] = '{8'd255, 8'd255, 8'd255, 8'd255, 0,      130050, 130050, 0};
        vecs[2] = '{8'd0,   8'd255, 8'd0,   8'd255, -65025, 0,      65025,  0};
        vecs[3] = '{8'd1,   8'd0,   8'd0,   8'd1,   0,      1,      0,      -1};

        // Reset state.
        #12;
        check("rst_valid", int'(ov0), 0);
        check("rst_re", sres(re0), 0);
        check("rst_im", sres(im0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", int'(ir0), 1);

        // Directed table.
        foreach (vecs[i])
            run_op(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi,
                   vecs[i].re0, vecs[i].im0, vecs[i].re1, vecs[i].im1,
                   $sformatf("vec%0d", i));

        // Randomized against the reference.
        for (int k = 0; k < 20; k++) begin
            r_ar = 8'($urandom); r_ai = 8'($urandom);
            r_br = 8'($urandom); r_bi = 8'($urandom);
            ref_mul(r_ar, r_ai, r_br, r_bi, 1'b0, e0r, e0i);
            ref_mul(r_ar, r_ai, r_br, r_bi, 1'b1, e1r, e1i);
            run_op(r_ar, r_ai, r_br, r_bi, e0r, e0i, e1r, e1i, $sformatf("rnd%0d", k));
        end

        // Backpressure in DONE, then back-to-back accept on release.
        @(negedge clk);
        ar = 8'd3; ai = 8'd4; br = 8'd5; bi = 8'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("hold_latency", lat, 4);
        hold_re = re0;
        hold_im = im0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ar = 8'($urandom); ai = 8'($urandom); br = 8'($urandom); bi = 8'($urandom);
            check($sformatf("hold%0d_valid", c), int'(ov0), 1);
            check($sformatf("hold%0d_ready", c), int'(ir0), 0);
            check($sformatf("hold%0d_re", c), sres(re0), -9);
            check($sformatf("hold%0d_im", c), sres(im0), 38);
            check($sformatf("hold%0d_stable", c), int'(re0 == hold_re && im0 == hold_im), 1);
        end
        @(negedge clk);
        ar = 8'd1; ai = 8'd2; br = 8'd3; bi = 8'd4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b_ready", int'(ir0), 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ar = 8'($urandom); ai = 8'($urandom); br = 8'($urandom); bi = 8'($urandom);
        check("b2b_valid_drop", int'(ov0), 0);
        wait_result(lat);
        check("b2b_latency", lat, 4);
        ref_mul(1, 2, 3, 4, 1'b0, e0r, e0i);
        ref_mul(1, 2, 3, 4, 1'b1, e1r, e1i);
        check_results("b2b", e0r, e0i, e1r, e1i);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of step 2 discards the operation.
        @(negedge clk);
        ar = 8'd200; ai = 8'd100; br = 8'd50; bi = 8'd25;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(ov0), 0);
        check("midrst_re", sres(re0), 0);
        check("midrst_im", sres(im0), 0);
        check("midrst_valid1", int'(ov1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", int'(ir0), 1);
        busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ov0 || ov1) busy++;
        end
        check("midrst_no_result", busy, 0);
        check("midrst_re_after", sres(re0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
